// File: rtl/uart_icb_feeder_if.sv
// ICB command/response bundle between the UART feeder (master) and the bus
// fabric or peripheral (slave).
interface uart_icb_feeder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/uart_icb_feeder.sv
// Feeds a byte stream into a memory-mapped UART over ICB: configures the UART
// once out of reset, then for every byte writes the data register and polls
// the CSR tx-done flag high and back low before taking the next byte.
module uart_icb_feeder #(
  parameter logic [31:0] DATA_ADDR = 32'h1000_4000,
  parameter logic [31:0] CSR_ADDR  = 32'h1000_4004,
  parameter logic [31:0] CTRL_ADDR = 32'h1000_4008,
  parameter logic [31:0] CSR_INIT  = 32'h0004_0201,
  parameter logic [31:0] CTRL_INIT = 32'h0000_0111,
  parameter int          DONE_BIT  = 4,
  parameter logic [15:0] POLL_MAX  = 16'd4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_data,
  uart_icb_feeder_if.master        icb,
  output logic                     init_done,
  output logic                     err,
  output logic [15:0]              tx_count
);

  typedef enum logic [3:0] {
    INIT_CSR_CMD, INIT_CSR_RSP,
    INIT_CTRL_CMD, INIT_CTRL_RSP,
    IDLE,
    WR_DATA_CMD, WR_DATA_RSP,
    POLL_SET_CMD, POLL_SET_RSP,
    POLL_CLR_CMD, POLL_CLR_RSP
  } state_t;

  state_t      state, state_n;
  logic [7:0]  byte_q;
  logic [15:0] poll_cnt;

  logic        is_rsp, cmd_fire, rsp_take, done_flag, poll_last;
  logic        init_set, err_set, tx_inc, byte_load, poll_clr, poll_inc;
  logic        nxt_valid, nxt_read;
  logic [31:0] nxt_addr, nxt_wdata;
  logic [7:0]  wr_byte;

  assign icb.rsp_ready = 1'b1;
  assign s_ready       = (state == IDLE) && init_done;
  assign is_rsp        = (state == INIT_CSR_RSP) || (state == INIT_CTRL_RSP) ||
                         (state == WR_DATA_RSP)  || (state == POLL_SET_RSP)  ||
                         (state == POLL_CLR_RSP);
  assign cmd_fire      = icb.cmd_valid && icb.cmd_ready;
  // A response counts only while one is owed: in a RSP phase, or in the same
  // cycle as our own command handshake. Stray responses after reset are dropped.
  assign rsp_take      = icb.rsp_valid && (is_rsp || cmd_fire);
  assign done_flag     = icb.rsp_rdata[DONE_BIT];
  assign poll_last     = (poll_cnt == POLL_MAX - 16'd1);
  assign wr_byte       = (state == IDLE) ? s_data : byte_q;

  // Next-state selection and one-cycle event strobes for the datapath.
  always_comb begin
    state_n   = state;
    init_set  = 1'b0;
    err_set   = 1'b0;
    tx_inc    = 1'b0;
    byte_load = 1'b0;
    poll_clr  = 1'b0;
    poll_inc  = 1'b0;
    case (state)
      INIT_CSR_CMD, INIT_CSR_RSP: begin
        if (rsp_take)      state_n = INIT_CTRL_CMD;
        else if (cmd_fire) state_n = INIT_CSR_RSP;
      end
      INIT_CTRL_CMD, INIT_CTRL_RSP: begin
        if (rsp_take) begin
          state_n  = IDLE;
          init_set = 1'b1;
        end else if (cmd_fire) begin
          state_n = INIT_CTRL_RSP;
        end
      end
      IDLE: begin
        if (s_valid && s_ready) begin
          state_n   = WR_DATA_CMD;
          byte_load = 1'b1;
        end
      end
      WR_DATA_CMD, WR_DATA_RSP: begin
        if (rsp_take) begin
          state_n  = POLL_SET_CMD;
          poll_clr = 1'b1;
        end else if (cmd_fire) begin
          state_n = WR_DATA_RSP;
        end
      end
      POLL_SET_CMD, POLL_SET_RSP: begin
        if (rsp_take) begin
          if (done_flag) begin
            state_n  = POLL_CLR_CMD;
            poll_clr = 1'b1;
          end else if (poll_last) begin
            state_n = IDLE;
            err_set = 1'b1;
          end else begin
            state_n  = POLL_SET_CMD;
            poll_inc = 1'b1;
          end
        end else if (cmd_fire) begin
          state_n = POLL_SET_RSP;
        end
      end
      POLL_CLR_CMD, POLL_CLR_RSP: begin
        if (rsp_take) begin
          if (!done_flag) begin
            state_n = IDLE;
            tx_inc  = 1'b1;
          end else if (poll_last) begin
            state_n = IDLE;
            err_set = 1'b1;
          end else begin
            state_n  = POLL_CLR_CMD;
            poll_inc = 1'b1;
          end
        end else if (cmd_fire) begin
          state_n = POLL_CLR_RSP;
        end
      end
      default: state_n = INIT_CSR_CMD;
    endcase
  end

  // Command fields for the upcoming cycle; cmd_valid always drops for one
  // cycle after a handshake, even when the next phase issues another command.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_read  = 1'b0;
    nxt_addr  = 32'h0;
    nxt_wdata = 32'h0;
    case (state_n)
      INIT_CSR_CMD: begin
        nxt_valid = !cmd_fire;
        nxt_addr  = CSR_ADDR;
        nxt_wdata = CSR_INIT;
      end
      INIT_CTRL_CMD: begin
        nxt_valid = !cmd_fire;
        nxt_addr  = CTRL_ADDR;
        nxt_wdata = CTRL_INIT;
      end
      WR_DATA_CMD: begin
        nxt_valid = !cmd_fire;
        nxt_addr  = DATA_ADDR;
        nxt_wdata = {24'h0, wr_byte};
      end
      POLL_SET_CMD, POLL_CLR_CMD: begin
        nxt_valid = !cmd_fire;
        nxt_addr  = CSR_ADDR;
        nxt_read  = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT_CSR_CMD;
    else        state <= state_n;
  end

  // Registered ICB command outputs so reset drives them to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb.cmd_valid <= 1'b0;
      icb.cmd_addr  <= 32'h0;
      icb.cmd_read  <= 1'b0;
      icb.cmd_wdata <= 32'h0;
    end else begin
      icb.cmd_valid <= nxt_valid;
      icb.cmd_addr  <= nxt_addr;
      icb.cmd_read  <= nxt_read;
      icb.cmd_wdata <= nxt_wdata;
    end
  end

  // Byte latch, poll counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q    <= 8'h0;
      poll_cnt  <= 16'h0;
      init_done <= 1'b0;
      err       <= 1'b0;
      tx_count  <= 16'h0;
    end else begin
      if (byte_load) byte_q <= s_data;
      if (poll_clr)      poll_cnt <= 16'h0;
      else if (poll_inc) poll_cnt <= poll_cnt + 16'd1;
      if (init_set) init_done <= 1'b1;
      if (err_set)  err       <= 1'b1;
      if (tx_inc)   tx_count  <= tx_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_icb_feeder.sv
// Directed bench for uart_icb_feeder with a scripted / loopback ICB slave.
module tb_uart_icb_feeder;
  localparam logic [31:0] DATA_ADDR = 32'h1000_4000;
  localparam logic [31:0] CSR_ADDR  = 32'h1000_4004;
  localparam logic [31:0] CTRL_ADDR = 32'h1000_4008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        init_done;
  logic        err;
  logic [15:0] tx_count;

  uart_icb_feeder_if bus ();

  uart_icb_feeder #(.POLL_MAX(16'd8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .icb(bus),
    .init_done(init_done), .err(err), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave model state
  logic [31:0] log_addr[$];
  bit          log_read[$];
  logic [31:0] log_wdata[$];
  bit          script[$];
  logic [7:0]  rx_bytes[$];
  bit          stuck = 1'b0;
  bit          lb_en = 1'b0;
  int          lb_busy = 0;
  bit          lb_done = 1'b0;
  bit          inject = 1'b0;
  int          stall_left = 0;
  int          dv_cycles = 0;
  int          unstable = 0;
  int          b2b = 0;
  bit          hold = 1'b0;
  bit          after_fire = 1'b0;
  logic [64:0] held = '0;

  assign bus.cmd_ready = !(bus.cmd_valid && bus.cmd_addr == DATA_ADDR && stall_left != 0);

  // ICB slave: one-cycle response latency, CSR done bit from script, loopback or stuck value
  always @(posedge clk) begin
    logic bitv;
    if (lb_busy > 0) begin
      lb_busy--;
      if (lb_busy == 0) lb_done = 1'b1;
    end
    if (bus.cmd_valid) begin
      if (hold && ({bus.cmd_addr, bus.cmd_read, bus.cmd_wdata} != held)) unstable++;
      if (after_fire) b2b++;
      if (bus.cmd_addr == DATA_ADDR && !bus.cmd_read) dv_cycles++;
      hold = !bus.cmd_ready;
      held = {bus.cmd_addr, bus.cmd_read, bus.cmd_wdata};
    end else begin
      if (hold) unstable++;
      hold = 1'b0;
    end
    after_fire = bus.cmd_valid && bus.cmd_ready;
    if (bus.cmd_valid && bus.cmd_ready) begin
      log_addr.push_back(bus.cmd_addr);
      log_read.push_back(bus.cmd_read);
      log_wdata.push_back(bus.cmd_wdata);
      if (bus.cmd_addr == DATA_ADDR && !bus.cmd_read) begin
        rx_bytes.push_back(bus.cmd_wdata[7:0]);
        lb_busy = 3;
        lb_done = 1'b0;
      end
      if (bus.cmd_read) begin
        if (script.size() > 0) bitv = script.pop_front();
        else if (lb_en) begin
          bitv = lb_done;
          lb_done = 1'b0;
        end else bitv = stuck;
        bus.rsp_rdata <= 32'h5A5A_5AE0 | {27'd0, bitv, 4'd0};
      end else begin
        bus.rsp_rdata <= 32'hFFFF_FFFF;
      end
      bus.rsp_valid <= 1'b1;
    end else if (inject) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rdata <= 32'hFFFF_FFFF;
    end else begin
      bus.rsp_valid <= 1'b0;
    end
    if (bus.cmd_valid && bus.cmd_addr == DATA_ADDR && stall_left != 0)
      stall_left <= stall_left - 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_read.delete();
    log_wdata.delete();
  endtask

  // Sends one byte and waits for s_ready to return; starts and ends at a negedge.
  task automatic applyStimulus(input logic [7:0] b, output int low_cycles, output bit ok);
    int n = 0;
    low_cycles = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      ok = 1'b0;
      return;
    end
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    while (!s_ready && low_cycles < 400) begin
      low_cycles++;
      @(negedge clk);
    end
    ok = s_ready;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cmd_valid"}, {31'd0, bus.cmd_valid}, 32'd0);
    checkOutput({tag, "_cmd_addr"},  bus.cmd_addr, 32'd0);
    checkOutput({tag, "_cmd_read"},  {31'd0, bus.cmd_read}, 32'd0);
    checkOutput({tag, "_cmd_wdata"}, bus.cmd_wdata, 32'd0);
    checkOutput({tag, "_rsp_ready"}, {31'd0, bus.rsp_ready}, 32'd1);
    checkOutput({tag, "_s_ready"},   {31'd0, s_ready}, 32'd0);
    checkOutput({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    checkOutput({tag, "_err"},       {31'd0, err}, 32'd0);
    checkOutput({tag, "_tx_count"},  {16'd0, tx_count}, 32'd0);
  endtask

  task automatic checkInit(input string tag);
    int n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
    checkOutput({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
    checkOutput({tag, "_txn_count"}, log_addr.size(), 32'd2);
    if (log_addr.size() >= 2) begin
      checkOutput({tag, "_csr_addr"}, log_addr[0], CSR_ADDR);
      checkOutput({tag, "_csr_wdata"}, log_wdata[0], 32'h0004_0201);
      checkOutput({tag, "_csr_read"}, {31'd0, log_read[0]}, 32'd0);
      checkOutput({tag, "_ctrl_addr"}, log_addr[1], CTRL_ADDR);
      checkOutput({tag, "_ctrl_wdata"}, log_wdata[1], 32'h0000_0111);
      checkOutput({tag, "_ctrl_read"}, {31'd0, log_read[1]}, 32'd0);
    end
  endtask

  task automatic checkTxn(input string tag, input logic [7:0] b, input int exp_reads);
    int good = 0;
    checkOutput({tag, "_txn_count"}, log_addr.size(), 1 + exp_reads);
    if (log_addr.size() > 0) begin
      checkOutput({tag, "_data_addr"}, log_addr[0], DATA_ADDR);
      checkOutput({tag, "_data_wdata"}, log_wdata[0], {24'h0, b});
      checkOutput({tag, "_data_read"}, {31'd0, log_read[0]}, 32'd0);
    end
    for (int i = 1; i < log_addr.size(); i++)
      if (log_addr[i] == CSR_ADDR && log_read[i] && log_wdata[i] == 32'h0) good++;
    checkOutput({tag, "_csr_reads"}, good, exp_reads);
  endtask

  typedef struct {
    logic [7:0]  data;
    int          set_zeros;
    int          clr_ones;
    int          exp_reads;
    logic [15:0] exp_tx;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   low;
    bit   ok;
    string tag;

    vecs[0] = '{8'hA5, 2, 0, 4,  16'd1};
    vecs[1] = '{8'h3C, 0, 0, 2,  16'd2};
    vecs[2] = '{8'h00, 1, 2, 5,  16'd3};
    vecs[3] = '{8'h81, 7, 7, 16, 16'd4};
    vecs[4] = '{8'hFF, 3, 1, 6,  16'd5};

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h0;
    repeat (3) @(negedge clk);
    checkReset("por");
    rst_n = 1'b1;
    checkInit("init");

    $display("[TB] table-driven byte transfers");
    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("vec%0d", v);
      clearLog();
      for (int k = 0; k < vecs[v].set_zeros; k++) script.push_back(1'b0);
      script.push_back(1'b1);
      for (int k = 0; k < vecs[v].clr_ones; k++) script.push_back(1'b1);
      script.push_back(1'b0);
      applyStimulus(vecs[v].data, low, ok);
      checkOutput({tag, "_complete"}, {31'd0, ok}, 32'd1);
      checkOutput({tag, "_latency_ge6"}, {31'd0, low >= 6}, 32'd1);
      checkTxn(tag, vecs[v].data, vecs[v].exp_reads);
      checkOutput({tag, "_tx_count"}, {16'd0, tx_count}, {16'd0, vecs[v].exp_tx});
      checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    end

    $display("[TB] stalled data write");
    clearLog();
    dv_cycles = 0;
    stall_left = 3;
    script.push_back(1'b1);
    script.push_back(1'b0);
    applyStimulus(8'h5E, low, ok);
    checkOutput("stall_complete", {31'd0, ok}, 32'd1);
    checkOutput("stall_valid_cycles", dv_cycles, 32'd4);
    checkOutput("stall_unstable", unstable, 32'd0);
    checkTxn("stall", 8'h5E, 2);
    checkOutput("stall_tx_count", {16'd0, tx_count}, 32'd6);

    $display("[TB] poll timeout");
    clearLog();
    script.delete();
    stuck = 1'b0;
    applyStimulus(8'h42, low, ok);
    checkOutput("tmo_complete", {31'd0, ok}, 32'd1);
    checkTxn("tmo", 8'h42, 8);
    checkOutput("tmo_err", {31'd0, err}, 32'd1);
    checkOutput("tmo_tx_count", {16'd0, tx_count}, 32'd6);
    clearLog();
    script.push_back(1'b1);
    script.push_back(1'b0);
    applyStimulus(8'h43, low, ok);
    checkOutput("after_tmo_complete", {31'd0, ok}, 32'd1);
    checkTxn("after_tmo", 8'h43, 2);
    checkOutput("after_tmo_err", {31'd0, err}, 32'd1);
    checkOutput("after_tmo_tx_count", {16'd0, tx_count}, 32'd7);

    $display("[TB] reset during POLL_SET");
    clearLog();
    script.delete();
    stuck = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h99;
    @(posedge clk);
    #1 s_valid = 1'b0;
    for (int n = 0; n < 50 && log_addr.size() < 2; n++) @(negedge clk);
    checkOutput("rst_reached_poll", {31'd0, log_addr.size() >= 2}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkReset("midrst");
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    clearLog();
    rst_n = 1'b1;
    checkInit("reinit");
    checkOutput("reinit_tx_count", {16'd0, tx_count}, 32'd0);
    checkOutput("reinit_err", {31'd0, err}, 32'd0);

    $display("[TB] 256-byte loopback");
    clearLog();
    rx_bytes.delete();
    lb_busy = 0;
    lb_done = 1'b0;
    lb_en = 1'b1;
    for (int b = 0; b < 256; b++) begin
      applyStimulus(b[7:0], low, ok);
      if (!ok) begin
        checkOutput("lb_complete", {31'd0, ok}, 32'd1);
        break;
      end
    end
    begin
      int nwr = 0;
      int bad = 0;
      for (int i = 0; i < log_addr.size(); i++) begin
        if (log_addr[i] == DATA_ADDR && !log_read[i]) begin
          if (log_wdata[i] != {24'h0, nwr[7:0]}) bad++;
          nwr++;
        end
      end
      checkOutput("lb_writes", nwr, 32'd256);
      checkOutput("lb_order_errs", bad, 32'd0);
      checkOutput("lb_rx_count", rx_bytes.size(), 32'd256);
    end
    checkOutput("lb_tx_count", {16'd0, tx_count}, 32'd256);
    checkOutput("lb_err", {31'd0, err}, 32'd0);
    checkOutput("valid_after_handshake", b2b, 32'd0);
    checkOutput("cmd_stability", unstable, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
